// File: rtl/stopwatch_ctrl_if.sv
// Button/tick inputs and counter/display outputs of the stopwatch sequencer.
// The controller connects through the slave modport; the driver side uses master.
interface stopwatch_ctrl_if;
    logic       tick_1hz;
    logic       tick_2hz;
    logic       pause_pulse;
    logic       clear_pulse;
    logic       lap_pulse;
    logic       adj;
    logic       sel;
    logic       sec_at_max;
    logic       min_at_max;
    logic       sec_inc;
    logic       min_inc;
    logic       cnt_clr;
    logic       blank_min;
    logic       blank_sec;
    logic       freeze;
    logic       full;
    logic [2:0] state;

    modport slave (
        input  tick_1hz, tick_2hz, pause_pulse, clear_pulse, lap_pulse,
               adj, sel, sec_at_max, min_at_max,
        output sec_inc, min_inc, cnt_clr, blank_min, blank_sec, freeze, full, state
    );

    modport master (
        output tick_1hz, tick_2hz, pause_pulse, clear_pulse, lap_pulse,
               adj, sel, sec_at_max, min_at_max,
        input  sec_inc, min_inc, cnt_clr, blank_min, blank_sec, freeze, full, state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Run/pause/adjust sequencer for the MM:SS stopwatch counter, all outputs registered.
// Optional lap/freeze display hold is enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl #(
    parameter int ADJ_RATE = 1
) (
    input  logic             clk,
    input  logic             rst,
    stopwatch_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        PAUSE  = 3'd2,
        ADJUST = 3'd3,
        FULL   = 3'd4
    } state_t;

    localparam logic [3:0] ADJ_RELOAD = 4'(ADJ_RATE);

    state_t     state_q, state_d;
    logic [3:0] div_q, div_d;
    logic       phase_q, phase_d;
    logic       sec_inc_q, sec_inc_d;
    logic       min_inc_q, min_inc_d;
    logic       cnt_clr_q, cnt_clr_d;
    logic       blank_min_q, blank_min_d;
    logic       blank_sec_q, blank_sec_d;
    logic       full_q, full_d;
    logic [3:0] div_inc;

    assign div_inc = div_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        phase_d   = phase_q;
        sec_inc_d = 1'b0;
        min_inc_d = 1'b0;
        cnt_clr_d = 1'b0;

        if (bus.clear_pulse) begin
            cnt_clr_d = 1'b1;
            state_d   = bus.adj ? ADJUST : IDLE;
            div_d     = 4'd0;
            phase_d   = 1'b0;
        end else if (bus.adj && state_q != ADJUST) begin
            state_d = ADJUST;
            div_d   = 4'd0;
            phase_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.pause_pulse) state_d = RUN;
                end
                RUN: begin
                    // A tick in the same cycle as pause is counted before pausing.
                    if (bus.tick_1hz && bus.sec_at_max && bus.min_at_max) begin
                        state_d = FULL;
                    end else begin
                        if (bus.tick_1hz) begin
                            sec_inc_d = 1'b1;
                            min_inc_d = bus.sec_at_max;
                        end
                        if (bus.pause_pulse) state_d = PAUSE;
                    end
                end
                PAUSE: begin
                    if (bus.pause_pulse) state_d = RUN;
                end
                ADJUST: begin
                    if (!bus.adj) begin
                        state_d = PAUSE;
                    end else if (bus.tick_2hz) begin
                        phase_d = ~phase_q;
                        if (div_inc == ADJ_RELOAD) begin
                            div_d     = 4'd0;
                            min_inc_d = ~bus.sel;
                            sec_inc_d = bus.sel;
                        end else begin
                            div_d = div_inc;
                        end
                    end
                end
                FULL: begin
                    state_d = FULL;
                end
                default: state_d = IDLE;
            endcase
        end

        // Flags are derived from next-state values so they move with the strobes.
        full_d      = (state_d == FULL);
        blank_min_d = (state_d == ADJUST) && !bus.sel && phase_d;
        blank_sec_d = (state_d == ADJUST) &&  bus.sel && phase_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            div_q       <= 4'd0;
            phase_q     <= 1'b0;
            sec_inc_q   <= 1'b0;
            min_inc_q   <= 1'b0;
            cnt_clr_q   <= 1'b0;
            blank_min_q <= 1'b0;
            blank_sec_q <= 1'b0;
            full_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            phase_q     <= phase_d;
            sec_inc_q   <= sec_inc_d;
            min_inc_q   <= min_inc_d;
            cnt_clr_q   <= cnt_clr_d;
            blank_min_q <= blank_min_d;
            blank_sec_q <= blank_sec_d;
            full_q      <= full_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic freeze_q, freeze_d;

    // Any adj=1 cycle either enters or stays in ADJUST, where freeze is never held.
    always_comb begin
        freeze_d = freeze_q;
        if (bus.clear_pulse || bus.adj) begin
            freeze_d = 1'b0;
        end else if (state_q == RUN && bus.lap_pulse) begin
            freeze_d = ~freeze_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            freeze_q <= 1'b0;
        end else begin
            freeze_q <= freeze_d;
        end
    end

    assign bus.freeze = freeze_q;
`else
    logic unused_lap;
    assign unused_lap = bus.lap_pulse;
    assign bus.freeze = 1'b0;
`endif

    assign bus.sec_inc   = sec_inc_q;
    assign bus.min_inc   = min_inc_q;
    assign bus.cnt_clr   = cnt_clr_q;
    assign bus.blank_min = blank_min_q;
    assign bus.blank_sec = blank_sec_q;
    assign bus.full      = full_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Table-driven bench for stopwatch_ctrl (ADJ_RATE=2): one vector per clock cycle,
// plus hand-written asynchronous reset sequences.
module tb_stopwatch_ctrl;

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP = 1'b1;
`else
    localparam bit LAP = 1'b0;
`endif

    // Input masks: {tick_1hz, tick_2hz, pause, clear, lap, adj, sel, sec_at_max, min_at_max}
    localparam logic [8:0] T1 = 9'h100, T2 = 9'h080, P = 9'h040, C = 9'h020, L = 9'h010,
                           A  = 9'h008, S  = 9'h004, SM = 9'h002, MM = 9'h001;
    // Output masks: {sec_inc, min_inc, cnt_clr, blank_min, blank_sec, freeze, full, state[2:0]}
    localparam logic [9:0] SI = 10'h200, MI = 10'h100, CC = 10'h080, BM = 10'h040,
                           BS = 10'h020, FR = 10'h010, FU = 10'h008;

    typedef struct {
        logic [8:0] in;
        logic [9:0] exp;
    } vec_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    vec_t vecs[$];

    stopwatch_ctrl_if bus ();

    stopwatch_ctrl #(.ADJ_RATE(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] outs();
        return {bus.sec_inc, bus.min_inc, bus.cnt_clr, bus.blank_min, bus.blank_sec,
                bus.freeze, bus.full, bus.state};
    endfunction

    task automatic drive(input logic [8:0] in);
        {bus.tick_1hz, bus.tick_2hz, bus.pause_pulse, bus.clear_pulse, bus.lap_pulse,
         bus.adj, bus.sel, bus.sec_at_max, bus.min_at_max} = in;
    endtask

    task automatic check(input string name, input logic [9:0] exp);
        logic [9:0] e;
        logic [9:0] got;
        e   = LAP ? exp : (exp & ~FR);
        got = outs();
        tests++;
        if (got !== e) begin
            fails++;
            $display("FAIL %s: got si,mi,cc,bm,bs,fr,fu,st=%b required %b", name, got, e);
        end else begin
            $display("ok   %s: outputs %b", name, got);
        end
    endtask

    task automatic add(input logic [8:0] in, input logic [9:0] exp);
        vecs.push_back('{in: in, exp: exp});
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b0;
        drive(9'h000);

        add(9'h000,       10'd0);            // 0  idle
        add(P,            10'd1);            // 1  start
        add(T1,           SI | 10'd1);       // 2
        add(9'h000,       10'd1);
        add(T1,           SI | 10'd1);       // 4
        add(9'h000,       10'd1);
        add(T1,           SI | 10'd1);       // 6
        add(9'h000,       10'd1);
        add(T1 | SM,      SI | MI | 10'd1);  // 8  carry
        add(T1 | SM | MM, FU | 10'd4);       // 9  saturate
        add(T1 | SM | MM, FU | 10'd4);
        add(P,            FU | 10'd4);
        add(C,            CC | 10'd0);       // 12 clear to idle
        add(9'h000,       10'd0);
        add(P,            10'd1);
        add(T1 | P,       SI | 10'd2);       // 15 tick counted then pause
        add(T1,           10'd2);
        add(P,            10'd1);
        add(A,            10'd3);            // 18 enter adjust, minutes
        add(A | T2,       BM | 10'd3);
        add(A | T2,       MI | 10'd3);       // 20
        add(A | T2,       BM | 10'd3);
        add(A | T2,       MI | 10'd3);
        add(A | T1 | P,   10'd3);            // 23 ignored in adjust
        add(A | S | T2,   BS | 10'd3);       // 24 seconds
        add(A | S | T2,   SI | 10'd3);
        add(A | S,        10'd3);
        add(A | S | T2,   BS | 10'd3);
        add(9'h000,       10'd2);            // 28 leave adjust
        add(P,            10'd1);
        add(T1 | SM | MM, FU | 10'd4);       // 30
        add(C | A,        CC | 10'd3);       // 31 clear into adjust
        add(A | T2,       BM | 10'd3);
        add(C | A | T2,   CC | 10'd3);       // 33 clear wins, divider reset
        add(A | T2,       BM | 10'd3);
        add(9'h000,       10'd2);            // 35
        add(L,            10'd2);            // lap ignored in pause
        add(P,            10'd1);
        add(L,            FR | 10'd1);       // 38
        add(T1,           SI | FR | 10'd1);
        add(L,            10'd1);            // 40
        add(T1,           SI | 10'd1);       // 41

        repeat (3) @(posedge clk);
        #1 check("reset_hold", 10'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].in);
            @(posedge clk);
            #1 check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Asynchronous reset mid-RUN while a sec_inc strobe is showing.
        #2 rst = 1'b0;
        #1 check("async_reset_now", 10'd0);
        @(negedge clk);
        drive(9'h000);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 check("after_reset_idle", 10'd0);
        @(negedge clk);
        drive(T1);
        @(posedge clk);
        #1 check("idle_tick_ignored", 10'd0);
        @(negedge clk);
        drive(9'h000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
